// File: rtl/lfo_rom_sequencer_if.sv
// ROM bus shared between the LFO sequencer (master) and the sine ROM (slave).
// Read data is signed two's complement; the ROM returns it a fixed number of clocks after the address.
interface lfo_rom_sequencer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic                     rom_cs;
    logic [ADDR_W-1:0]        rom_addr;
    logic signed [DATA_W-1:0] rom_data;

    modport master (
        output rom_cs,
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  rom_cs,
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/lfo_rom_sequencer.sv
// Time-multiplexes NCH pan LFOs onto one shared sine ROM; each tick sweeps all channels in order.
// Optional per-channel modulation depth is enabled by defining LFO_DEPTH_EN.
module lfo_rom_sequencer #(
    parameter int                 NCH       = 4,
    parameter int                 PHASE_W   = 24,
    parameter int                 ADDR_W    = 12,
    parameter int                 DATA_W    = 16,
    parameter int                 ROM_LAT   = 1,
    parameter logic [PHASE_W-1:0] DEFAULT_F = PHASE_W'(24'h001B4F),
    localparam int                SEL_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   tick,
    input  logic                   f_we,
    input  logic [SEL_W-1:0]       f_sel,
    input  logic [PHASE_W-1:0]     f_data,
`ifdef LFO_DEPTH_EN
    input  logic                   d_we,
    input  logic [8:0]             d_data,
`endif
    lfo_rom_sequencer_if.master    rom,
    output logic [NCH*DATA_W-1:0]  pan_out,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] CAPT = 2'd3;

    localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic signed [DATA_W-1:0] MID = {2'b01, {(DATA_W-2){1'b0}}};

    logic [1:0]               state;
    logic [SEL_W-1:0]         ch;
    logic [CNT_W-1:0]         wcnt;
    logic [PHASE_W-1:0]       phase [NCH];
    logic [PHASE_W-1:0]       freq  [NCH];
    logic signed [DATA_W-1:0] pan_r [NCH];
    logic [PHASE_W-1:0]       phase_nxt;
    logic signed [DATA_W-1:0] gain_capt;
    logic                     last_ch;
    logic                     sel_ok;

`ifdef LFO_DEPTH_EN
    logic [8:0] depth [NCH];

    function automatic logic [8:0] sat_depth(input logic [8:0] d);
        return (d > 9'd256) ? 9'd256 : d;
    endfunction

    // Scale the halved sine by depth/256 before re-centring on mid-scale.
    function automatic logic signed [DATA_W-1:0] to_gain(
        input logic signed [DATA_W-1:0] d,
        input logic [8:0]               dep
    );
        logic signed [DATA_W+9:0] prod;
        logic signed [DATA_W+9:0] prod_sh;
        prod    = (DATA_W+10)'(d >>> 1) * (DATA_W+10)'($signed({1'b0, dep}));
        prod_sh = prod >>> 8;
        return prod_sh[DATA_W-1:0] + MID;
    endfunction

    assign gain_capt = to_gain(rom.rom_data, depth[ch]);
`else
    function automatic logic signed [DATA_W-1:0] to_gain(input logic signed [DATA_W-1:0] d);
        return (d >>> 1) + MID;
    endfunction

    assign gain_capt = to_gain(rom.rom_data);
`endif

    assign phase_nxt = phase[ch] + freq[ch];
    assign last_ch   = (32'(ch) == NCH - 1);
    assign sel_ok    = (32'(f_sel) < NCH);

    always_comb begin
        pan_out = '0;
        for (int k = 0; k < NCH; k++) begin
            pan_out[k*DATA_W +: DATA_W] = pan_r[k];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            ch           <= '0;
            wcnt         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
            rom.rom_cs   <= 1'b0;
            rom.rom_addr <= '0;
            for (int k = 0; k < NCH; k++) begin
                phase[k] <= '0;
                freq[k]  <= DEFAULT_F;
                pan_r[k] <= MID;
`ifdef LFO_DEPTH_EN
                depth[k] <= 9'd256;
`endif
            end
        end else begin
            done <= 1'b0;
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        ch    <= '0;
                        state <= ADDR;
                    end
                end
                // Phase step and ROM address issue for the current channel.
                ADDR: begin
                    phase[ch]    <= phase_nxt;
                    rom.rom_addr <= phase_nxt[PHASE_W-1 -: ADDR_W];
                    rom.rom_cs   <= 1'b1;
                    busy         <= 1'b1;
                    wcnt         <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (32'(wcnt) == ROM_LAT - 1) begin
                        state <= CAPT;
                    end else begin
                        wcnt <= wcnt + CNT_W'(1);
                    end
                end
                // ROM data is valid here; convert and commit this channel's gain.
                CAPT: begin
                    pan_r[ch]  <= gain_capt;
                    rom.rom_cs <= 1'b0;
                    if (last_ch) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        ch    <= ch + SEL_W'(1);
                        state <= ADDR;
                    end
                end
                default: state <= IDLE;
            endcase
            if (f_we && sel_ok) begin
                freq[f_sel] <= f_data;
            end
`ifdef LFO_DEPTH_EN
            if (d_we && sel_ok) begin
                depth[f_sel] <= sat_depth(d_data);
            end
`endif
        end
    end

endmodule

// File: tb/tb_lfo_rom_sequencer.sv
// Randomized bench for lfo_rom_sequencer against a sweep-timeline reference model.
// ROM model: one clock latency, data = {addr, 4'h0}.
module tb_lfo_rom_sequencer;
  localparam int NCH = 4;
  localparam int PER = 3;            // clocks per channel with ROM_LAT = 1
  localparam int SW  = NCH * PER;    // edges from tick to done

  logic        clk = 1'b0;
  logic        rst, tick, f_we;
  logic [1:0]  f_sel;
  logic [23:0] f_data;
  logic [63:0] pan_out;
  logic        busy, done, overrun;

  always #5 clk = ~clk;

  lfo_rom_sequencer_if #(.ADDR_W(12), .DATA_W(16)) rom_bus ();

  always @(posedge clk) begin
    if (rom_bus.rom_cs) rom_bus.rom_data <= {rom_bus.rom_addr, 4'h0};
  end

  lfo_rom_sequencer #(
    .NCH(NCH), .PHASE_W(24), .ADDR_W(12), .DATA_W(16), .ROM_LAT(1), .DEFAULT_F(24'h001B4F)
  ) dut (
    .Clk(clk), .Reset(rst), .tick(tick), .f_we(f_we), .f_sel(f_sel), .f_data(f_data),
    .rom(rom_bus), .pan_out(pan_out), .busy(busy), .done(done), .overrun(overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: o = edges since the tick that started the current sweep (-1 when none).
  int          o = -1;
  logic [23:0] m_phase [NCH];
  logic [23:0] m_freq  [NCH];
  logic [15:0] m_pan   [NCH];
  logic [11:0] m_addr;
  logic        m_ovr;

  function automatic logic [15:0] gain(input logic [11:0] a);
    int v;
    v = $signed({a, 4'h0});
    v = v / 2 + 16384;               // exact: sample is always even
    return 16'(v);
  endfunction

  task automatic model_edge();
    int k;
    if (rst) begin
      o = -1; m_ovr = 1'b0; m_addr = '0;
      for (int i = 0; i < NCH; i++) begin
        m_phase[i] = '0; m_freq[i] = 24'h001B4F; m_pan[i] = 16'h4000;
      end
    end else begin
      if (o < 0 || o >= SW) begin
        o = tick ? 0 : -1;
      end else begin
        o++;
        if (tick) m_ovr = 1'b1;
        if ((o - 1) % PER == 0) begin
          k = (o - 1) / PER;
          m_phase[k] = m_phase[k] + m_freq[k];
          m_addr = m_phase[k][23:12];
        end
        if (o % PER == 0) begin
          k = o / PER - 1;
          m_pan[k] = gain(m_addr);
        end
      end
      if (f_we && int'(f_sel) < NCH) m_freq[f_sel] = f_data;
    end
  endtask

  task automatic check_outputs();
    logic exp_cs;
    exp_cs = (o >= 1 && o <= SW && o % PER != 0);
    check("pan_out", pan_out, {m_pan[3], m_pan[2], m_pan[1], m_pan[0]});
    check("busy", busy, 64'(o >= 1 && o < SW));
    check("done", done, 64'(o == SW));
    check("overrun", overrun, m_ovr);
    check("rom_cs", rom_bus.rom_cs, exp_cs);
    if (exp_cs) check("rom_addr", rom_bus.rom_addr, m_addr);
  endtask

  task automatic step(input logic t, input logic w, input logic [1:0] s,
                      input logic [23:0] d, input logic r);
    tick = t; f_we = w; f_sel = s; f_data = d; rst = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 24'd0, 1'b0);
  endtask

  int done_at, busy_cnt;

  initial begin
    step(1'b0, 1'b0, 2'd0, 24'd0, 1'b1);
    step(1'b0, 1'b0, 2'd0, 24'd0, 1'b1);
    check("rst_pan", pan_out, {4{16'h4000}});
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_cs", rom_bus.rom_cs, 1'b0);

    // ch0 at 24'h100000: address 0x100, gain 0x4800, done 12 edges after tick
    step(1'b0, 1'b1, 2'd0, 24'h100000, 1'b0);
    step(1'b1, 1'b0, 2'd0, 24'd0, 1'b0);
    done_at = -1; busy_cnt = 0;
    for (int i = 1; i <= SW + 2; i++) begin
      step(1'b0, 1'b0, 2'd0, 24'd0, 1'b0);
      if (i == 1) check("ch0_addr", rom_bus.rom_addr, 12'h100);
      if (busy) busy_cnt++;
      if (done && done_at < 0) done_at = i;
    end
    check("done_latency", done_at, SW);
    check("busy_cycles", busy_cnt, SW - 1);
    check("ch0_gain", pan_out[15:0], 16'h4800);

    // ch1 at 24'hF00000 over two sweeps wraps to 24'hE00000
    step(1'b0, 1'b0, 2'd0, 24'd0, 1'b1);
    step(1'b0, 1'b1, 2'd1, 24'hF00000, 1'b0);
    step(1'b1, 1'b0, 2'd0, 24'd0, 1'b0);
    idle(SW + 1);
    step(1'b1, 1'b0, 2'd0, 24'd0, 1'b0);
    idle(SW + 1);
    check("ch1_wrap_gain", pan_out[31:16], 16'h3000);

    // tick at cycle 3 of a sweep: ignored, overrun sticks, done still at 12
    step(1'b0, 1'b0, 2'd0, 24'd0, 1'b1);
    step(1'b1, 1'b0, 2'd0, 24'd0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 2'd0, 24'd0, 1'b0);
    done_at = -1;
    for (int i = 4; i <= SW + 3; i++) begin
      step(1'b0, 1'b0, 2'd0, 24'd0, 1'b0);
      if (done && done_at < 0) done_at = i;
    end
    check("ovr_done_latency", done_at, SW);
    check("ovr_sticky", overrun, 1'b1);

    // f_we to ch3 during ch0 capture, then reset at cycle 5
    step(1'b0, 1'b0, 2'd0, 24'd0, 1'b1);
    step(1'b1, 1'b0, 2'd0, 24'd0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 2'd3, 24'h0A0000, 1'b0);
    idle(SW);
    check("ch3_new_freq", pan_out[63:48], gain(12'h0A0));
    step(1'b1, 1'b0, 2'd0, 24'd0, 1'b0);
    idle(4);
    step(1'b0, 1'b0, 2'd0, 24'd0, 1'b1);
    check("midsweep_rst_pan", pan_out, {4{16'h4000}});
    check("midsweep_rst_busy", busy, 1'b0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0,
           2'($urandom),
           ($urandom_range(0, 9) == 0) ? 24'd0 : 24'($urandom),
           $urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
